// File: rtl/grid_cursor_ctrl.sv
// Cursor controller for a ROWS x COLS board: debounced five-button navigation with wrap/saturate edges.
// Optional build macro AUTOREPEAT_EN adds hold-to-repeat moves (HOLD_CYC initial delay, RPT_CYC period).
module grid_cursor_ctrl #(
  parameter int ROWS    = 3,
  parameter int COLS    = 3,
  parameter int DEB_CYC = 16,
  parameter int WRAP    = 1
`ifdef AUTOREPEAT_EN
  ,
  parameter int HOLD_CYC = 50_000_000,
  parameter int RPT_CYC  = 10_000_000
`endif
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     btn_left,
  input  logic                                     btn_right,
  input  logic                                     btn_up,
  input  logic                                     btn_down,
  input  logic                                     btn_center,
  input  logic                                     clear,
  output logic [ROWS*COLS-1:0]                     cursor,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] cur_row,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] cur_col,
  output logic                                     write,
  output logic                                     bump
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [RW-1:0] ROW_MID = RW'((ROWS - 1) / 2);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MID = CW'((COLS - 1) / 2);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  typedef enum logic [1:0] {DIR_L, DIR_R, DIR_U, DIR_D} dir_e;

  // Bit order: 0 left, 1 right, 2 up, 3 down, 4 centre
  logic [4:0]    raw, sync_a, sync_b, deb, deb_q, qual, press;
  logic [1:0]    live;
  logic [DW-1:0] deb_cnt [5];
  logic          arm, mv_req, nxt_bump;
  dir_e          mv_dir;
  logic [RW-1:0] nxt_row;
  logic [CW-1:0] nxt_col;

  assign raw = {btn_center, btn_down, btn_up, btn_right, btn_left};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
      live   <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      live   <= {live[0], 1'b1};
    end
  end

  // qual blocks a press from a button that was already held when reset released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb   <= '0;
      deb_q <= '0;
      qual  <= '0;
      for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
    end else begin
      deb_q <= deb;
      qual  <= qual | ({5{live[1]}} & ~sync_b);
      for (int i = 0; i < 5; i++) begin
        if (sync_b[i] != deb[i]) begin
          if (deb_cnt[i] == DW'(DEB_CYC - 1)) begin
            deb[i]     <= sync_b[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = deb & ~deb_q & qual;

`ifdef AUTOREPEAT_EN
  localparam int PW = $clog2((HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC) + 1;
  logic          rpt_on, rpt_fire, held_only;
  logic [PW-1:0] rpt_cnt;
  dir_e          last_dir;

  assign held_only = (deb[3:0] == (4'b0001 << last_dir));
  assign rpt_fire  = rpt_on && !arm && held_only && (rpt_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_on   <= 1'b0;
      rpt_cnt  <= '0;
      last_dir <= DIR_L;
    end else if (mv_req && !clear) begin
      rpt_on   <= 1'b1;
      last_dir <= mv_dir;
      rpt_cnt  <= rpt_fire ? PW'(RPT_CYC - 1) : PW'(HOLD_CYC - 1);
    end else if (rpt_on && (clear || !held_only)) begin
      rpt_on <= 1'b0;
    end else if (rpt_on && rpt_cnt != '0) begin
      rpt_cnt <= rpt_cnt - 1'b1;
    end
  end
`endif

  always_comb begin
    mv_req   = 1'b0;
    mv_dir   = DIR_L;
    nxt_row  = cur_row;
    nxt_col  = cur_col;
    nxt_bump = 1'b0;
    if (arm && |press[3:0]) begin
      mv_req = 1'b1;
      if (press[0])      mv_dir = DIR_L;
      else if (press[1]) mv_dir = DIR_R;
      else if (press[2]) mv_dir = DIR_U;
      else               mv_dir = DIR_D;
    end
`ifdef AUTOREPEAT_EN
    else if (rpt_fire) begin
      mv_req = 1'b1;
      mv_dir = last_dir;
    end
`endif
    if (mv_req) begin
      case (mv_dir)
        DIR_L: if (cur_col != '0) nxt_col = cur_col - 1'b1;
               else if (WRAP != 0) nxt_col = COL_MAX;
               else nxt_bump = 1'b1;
        DIR_R: if (cur_col != COL_MAX) nxt_col = cur_col + 1'b1;
               else if (WRAP != 0) nxt_col = '0;
               else nxt_bump = 1'b1;
        DIR_U: if (cur_row != '0) nxt_row = cur_row - 1'b1;
               else if (WRAP != 0) nxt_row = ROW_MAX;
               else nxt_bump = 1'b1;
        default: if (cur_row != ROW_MAX) nxt_row = cur_row + 1'b1;
                 else if (WRAP != 0) nxt_row = '0;
                 else nxt_bump = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_row <= ROW_MID;
      cur_col <= COL_MID;
      write   <= 1'b0;
      bump    <= 1'b0;
      arm     <= 1'b1;
    end else begin
      write <= press[4];
      if (clear) begin
        cur_row <= ROW_MID;
        cur_col <= COL_MID;
        bump    <= 1'b0;
      end else begin
        cur_row <= nxt_row;
        cur_col <= nxt_col;
        bump    <= nxt_bump;
      end
      if (mv_req)              arm <= 1'b0;
      else if (~|deb[3:0])     arm <= 1'b1;
    end
  end

  always_comb begin
    cursor = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        cursor[r*COLS+c] = (cur_row == RW'(r)) && (cur_col == CW'(c));
  end

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// Scoreboard bench: three boards (3x3 wrap, 3x3 saturate, 4x5 wrap) share the button pads.
`timescale 1ns/1ps
module tb_grid_cursor_ctrl;
  localparam int DEB = 4;
  localparam logic [4:0] B_L = 5'b00001, B_R = 5'b00010, B_U = 5'b00100,
                         B_D = 5'b01000, B_C = 5'b10000;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [4:0] raw = '0;
  logic [8:0] cur0, cur1;
  logic [19:0] cur2;
  logic [1:0] r0, c0, r1, c1, r2;
  logic [2:0] c2;
  logic wr0, wr1, wr2, bp0, bp1, bp2;

  always #5 clk = ~clk;

  grid_cursor_ctrl #(.ROWS(3), .COLS(3), .DEB_CYC(DEB), .WRAP(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .btn_left(raw[0]), .btn_right(raw[1]), .btn_up(raw[2]),
    .btn_down(raw[3]), .btn_center(raw[4]), .clear(clear), .cursor(cur0),
    .cur_row(r0), .cur_col(c0), .write(wr0), .bump(bp0));
  grid_cursor_ctrl #(.ROWS(3), .COLS(3), .DEB_CYC(DEB), .WRAP(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .btn_left(raw[0]), .btn_right(raw[1]), .btn_up(raw[2]),
    .btn_down(raw[3]), .btn_center(raw[4]), .clear(clear), .cursor(cur1),
    .cur_row(r1), .cur_col(c1), .write(wr1), .bump(bp1));
  grid_cursor_ctrl #(.ROWS(4), .COLS(5), .DEB_CYC(DEB), .WRAP(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .btn_left(raw[0]), .btn_right(raw[1]), .btn_up(raw[2]),
    .btn_down(raw[3]), .btn_center(raw[4]), .clear(clear), .cursor(cur2),
    .cur_row(r2), .cur_col(c2), .write(wr2), .bump(bp2));

  typedef struct {int cyc; int row; int col; logic wr; logic bump;} exp_t;
  exp_t q0[$], q1[$], q2[$];
  int checks = 0, errors = 0, cyc = 0;
  int m_row[3], m_col[3];
  int n_rows[3] = '{3, 3, 4};
  int n_cols[3] = '{3, 3, 5};
  int wrap[3]   = '{1, 0, 1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int d, input logic [31:0] obs,
                           input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s dut%0d got %0h expected %0h (cycle %0d)", tag, d, obs, exp_v, cyc);
    end
  endtask

  function automatic void get_out(input int d, output int row, output int col,
                                  output logic [31:0] cur, output logic wr, output logic bp);
    case (d)
      0: begin row = int'(r0); col = int'(c0); cur = 32'(cur0); wr = wr0; bp = bp0; end
      1: begin row = int'(r1); col = int'(c1); cur = 32'(cur1); wr = wr1; bp = bp1; end
      default: begin row = int'(r2); col = int'(c2); cur = 32'(cur2); wr = wr2; bp = bp2; end
    endcase
  endfunction

  function automatic int q_size(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t q_front(input int d);
    case (d)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void q_pop(input int d);
    exp_t e;
    case (d)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endfunction

  function automatic void q_push(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic logic [31:0] onehot(input int d, input int row, input int col);
    logic [31:0] one;
    one = 32'd1;
    return one << (row * n_cols[d] + col);
  endfunction

  // Reference behaviour for one accepted press on every board
  task automatic model_press(input logic [4:0] m, input bit clr, input int at);
    int nr, nc;
    logic b;
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      nr = m_row[d]; nc = m_col[d]; b = 1'b0;
      if (clr) begin
        nr = (n_rows[d] - 1) / 2; nc = (n_cols[d] - 1) / 2;
      end else if (m[0]) begin
        if (nc > 0) nc--; else if (wrap[d] != 0) nc = n_cols[d] - 1; else b = 1'b1;
      end else if (m[1]) begin
        if (nc < n_cols[d] - 1) nc++; else if (wrap[d] != 0) nc = 0; else b = 1'b1;
      end else if (m[2]) begin
        if (nr > 0) nr--; else if (wrap[d] != 0) nr = n_rows[d] - 1; else b = 1'b1;
      end else if (m[3]) begin
        if (nr < n_rows[d] - 1) nr++; else if (wrap[d] != 0) nr = 0; else b = 1'b1;
      end
      if (nr != m_row[d] || nc != m_col[d] || m[4] || b) begin
        e.cyc = at; e.row = nr; e.col = nc; e.wr = m[4]; e.bump = b;
        q_push(d, e);
      end
      m_row[d] = nr; m_col[d] = nc;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_row[d] = (n_rows[d] - 1) / 2;
      m_col[d] = (n_cols[d] - 1) / 2;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raw level held for 'hold' cycles; clear optionally raised in the press-event cycle
  task automatic press(input logic [4:0] m, input int hold, input bit clr);
    int k;
    k = cyc;
    raw = m;
    if (hold >= DEB) model_press(m, clr, k + DEB + 3);
    for (int i = 0; i < hold; i++) begin
      clear = clr && (i == 6);
      @(posedge clk);
      #1;
    end
    clear = 1'b0;
    raw = '0;
    wait_cyc(14);
  endtask

  logic [31:0] prev_cur [3];
  always @(negedge clk) begin
    int row, col;
    logic [31:0] cur;
    logic wr, bp;
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      get_out(d, row, col, cur, wr, bp);
      if (rst_n) begin
        if (q_size(d) > 0) begin
          e = q_front(d);
          if (e.cyc < cyc) begin
            check_val("late_event", d, cyc, e.cyc);
            q_pop(d);
          end
        end
        if (cur != prev_cur[d] || wr || bp) begin
          check_val("event_expected", d, (q_size(d) > 0) ? 1 : 0, 1);
          if (q_size(d) > 0) begin
            e = q_front(d);
            q_pop(d);
            check_val("latency", d, cyc, e.cyc);
            check_val("row", d, row, e.row);
            check_val("col", d, col, e.col);
            check_val("cursor", d, cur, onehot(d, e.row, e.col));
            check_val("write", d, 32'(wr), 32'(e.wr));
            check_val("bump", d, 32'(bp), 32'(e.bump));
          end
        end
      end
      prev_cur[d] = cur;
    end
  end

  task automatic check_idle(input string tag);
    int row, col;
    logic [31:0] cur;
    logic wr, bp;
    for (int d = 0; d < 3; d++) begin
      get_out(d, row, col, cur, wr, bp);
      check_val({tag, "_row"}, d, row, m_row[d]);
      check_val({tag, "_col"}, d, col, m_col[d]);
      check_val({tag, "_cursor"}, d, cur, onehot(d, m_row[d], m_col[d]));
      check_val({tag, "_write"}, d, 32'(wr), 0);
      check_val({tag, "_bump"}, d, 32'(bp), 0);
    end
  endtask

  initial begin
    int k;
    model_reset();
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(1);
    check_idle("reset");
    wait_cyc(5);

    press(B_R, 10, 1'b0);
    press(B_U, 3, 1'b0);
    press(B_U, 8, 1'b0);
    press(B_U, 8, 1'b0);
    repeat (4) press(B_L, 6, 1'b0);
    press(B_L | B_D, 10, 1'b0);

    k = cyc;
    raw = B_L;
    model_press(B_L, 1'b0, k + DEB + 3);
    wait_cyc(8);
    raw = B_L | B_D;
    wait_cyc(8);
    raw = B_D;
    wait_cyc(8);
    raw = '0;
    wait_cyc(14);

    press(B_R | B_C, 10, 1'b1);
    repeat (3) press(B_R, 5, 1'b0);
    repeat (2) press(B_U, 5, 1'b0);
    press(B_C, 5, 1'b0);
    press(B_D, 4, 1'b0);
    check_idle("settled");

    raw = B_R;
    wait_cyc(3);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_idle("async_reset");
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(20);
    raw = '0;
    wait_cyc(14);
    check_idle("held_thru_reset");
    press(B_R, 6, 1'b0);

    wait_cyc(20);
    for (int d = 0; d < 3; d++) check_val("queue_drained", d, q_size(d), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
